// File: rtl/packetizer_pkg.sv
// Shared state encoding, default framing constant and packet-length helper for
// the sample packetizer and the host-side packet model.
package packetizer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_SYNC = 3'd1,
        ST_SEQ  = 3'd2,
        ST_DATA = 3'd3,
        ST_CSUM = 3'd4
    } pkt_state_t;

    localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

    // Bytes per packet: sync, sequence, two bytes per channel, checksum.
    function automatic int unsigned pkt_len(input int unsigned num_channels);
        return 32'd3 + (32'd2 * num_channels);
    endfunction

endpackage

// File: rtl/sample_packetizer.sv
// Serialises one multi-channel ADC frame per input beat into a byte packet:
// SYNC, sequence number, big-endian samples, additive checksum.
module sample_packetizer
    import packetizer_pkg::*;
#(
    parameter int         NUM_CHANNELS = 2,
    parameter logic [7:0] SYNC_BYTE    = DEFAULT_SYNC_BYTE
) (
    input  logic                         sys_clk,
    input  logic                         sys_rst,
    input  logic [16*NUM_CHANNELS-1:0]   s_axis_tdata,
    input  logic                         s_axis_tvalid,
    output logic                         s_axis_tready,
    output logic [7:0]                   m_axis_tdata,
    output logic                         m_axis_tvalid,
    input  logic                         m_axis_tready,
    output logic                         busy,
    output logic [7:0]                   seq_num
);

    localparam int DATA_W    = 16 * NUM_CHANNELS;
    localparam int NUM_BYTES = 2 * NUM_CHANNELS;
    localparam int IDX_W     = $clog2(NUM_BYTES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BYTES - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
    localparam logic [IDX_W-1:0] IDX_ZERO = IDX_W'(0);

    // Sample byte idx in wire order: channel idx/2, high byte on even idx,
    // which lands at bit offset 8*(idx^1) of the frame.
    function automatic logic [7:0] sample_byte(input logic [DATA_W-1:0] frame,
                                               input logic [IDX_W-1:0]  idx);
        logic [7:0] result;
        result = 8'h00;
        for (int b = 0; b < NUM_BYTES; b++) begin
            if (idx == IDX_W'(b)) begin
                result = frame[8*(b ^ 1) +: 8];
            end
        end
        return result;
    endfunction

    pkt_state_t        state_r;
    pkt_state_t        state_s;
    logic [DATA_W-1:0] hold_r;
    logic [DATA_W-1:0] hold_s;
    logic [7:0]        csum_r;
    logic [7:0]        csum_s;
    logic [IDX_W-1:0]  idx_r;
    logic [IDX_W-1:0]  idx_s;
    logic              s_ready_s;
    logic              m_valid_s;
    logic [7:0]        m_data_s;
    logic              busy_s;
    logic [7:0]        seq_s;
    logic [7:0]        byte_s;

    // Next-state and next-output logic for the packet sequencer.
    always_comb begin
        state_s   = state_r;
        hold_s    = hold_r;
        csum_s    = csum_r;
        idx_s     = idx_r;
        s_ready_s = s_axis_tready;
        m_valid_s = m_axis_tvalid;
        m_data_s  = m_axis_tdata;
        busy_s    = busy;
        seq_s     = seq_num;
        byte_s    = 8'h00;

        case (state_r)
            ST_IDLE: begin
                s_ready_s = 1'b1;
                if (s_axis_tvalid && s_axis_tready) begin
                    hold_s    = s_axis_tdata;
                    csum_s    = 8'h00;
                    s_ready_s = 1'b0;
                    m_data_s  = SYNC_BYTE;
                    m_valid_s = 1'b1;
                    busy_s    = 1'b1;
                    state_s   = ST_SYNC;
                end else begin
                    state_s   = ST_IDLE;
                end
            end
            ST_SYNC: begin
                if (m_axis_tready) begin
                    m_data_s = seq_num;
                    csum_s   = csum_r + seq_num;
                    state_s  = ST_SEQ;
                end else begin
                    state_s  = ST_SYNC;
                end
            end
            ST_SEQ: begin
                byte_s = sample_byte(hold_r, IDX_ZERO);
                if (m_axis_tready) begin
                    m_data_s = byte_s;
                    csum_s   = csum_r + byte_s;
                    idx_s    = IDX_ZERO;
                    state_s  = ST_DATA;
                end else begin
                    state_s  = ST_SEQ;
                end
            end
            ST_DATA: begin
                byte_s = sample_byte(hold_r, idx_r + IDX_ONE);
                if (m_axis_tready) begin
                    if (idx_r == LAST_IDX) begin
                        // Checksum already covers every loaded byte.
                        m_data_s = csum_r;
                        state_s  = ST_CSUM;
                    end else begin
                        m_data_s = byte_s;
                        csum_s   = csum_r + byte_s;
                        idx_s    = idx_r + IDX_ONE;
                        state_s  = ST_DATA;
                    end
                end else begin
                    state_s = ST_DATA;
                end
            end
            ST_CSUM: begin
                if (m_axis_tready) begin
                    m_valid_s = 1'b0;
                    busy_s    = 1'b0;
                    s_ready_s = 1'b1;
                    seq_s     = seq_num + 8'd1;
                    state_s   = ST_IDLE;
                end else begin
                    state_s   = ST_CSUM;
                end
            end
            default: begin
                state_s   = ST_IDLE;
                m_valid_s = 1'b0;
                busy_s    = 1'b0;
                s_ready_s = 1'b0;
            end
        endcase
    end

    // State, holding register and registered outputs.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_r       <= ST_IDLE;
            hold_r        <= {DATA_W{1'b0}};
            csum_r        <= 8'h00;
            idx_r         <= IDX_ZERO;
            s_axis_tready <= 1'b0;
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= 8'h00;
            busy          <= 1'b0;
            seq_num       <= 8'h00;
        end else begin
            state_r       <= state_s;
            hold_r        <= hold_s;
            csum_r        <= csum_s;
            idx_r         <= idx_s;
            s_axis_tready <= s_ready_s;
            m_axis_tvalid <= m_valid_s;
            m_axis_tdata  <= m_data_s;
            busy          <= busy_s;
            seq_num       <= seq_s;
        end
    end

endmodule

// File: tb/tb_sample_packetizer.sv
// Self-checking bench for sample_packetizer: directed frames, randomized
// backpressure and back-to-back streams against a packet-level model.
module tb_sample_packetizer;
    import packetizer_pkg::*;

    localparam int NC = 2;
    localparam int PL = int'(pkt_len(NC));
    localparam int PL1 = int'(pkt_len(1));

    logic           sys_clk  = 1'b0;
    logic           sys_rst  = 1'b1;
    logic [31:0]    s_tdata  = 32'h0;
    logic           s_tvalid = 1'b0;
    logic           s_tready;
    logic [7:0]     m_tdata;
    logic           m_tvalid;
    logic           m_tready = 1'b0;
    logic           busy;
    logic [7:0]     seq_num;

    logic           rst1      = 1'b1;
    logic [15:0]    s1_tdata  = 16'h0;
    logic           s1_tvalid = 1'b0;
    logic           s1_tready;
    logic [7:0]     m1_tdata;
    logic           m1_tvalid;
    logic           m1_tready = 1'b0;
    logic           busy1;
    logic [7:0]     seq1;

    int checks   = 0;
    int failures = 0;

    logic [31:0] frame_q[$];
    logic [7:0]  exp_q[$];
    logic [7:0]  got_q[$];
    int          s_acc_t[$];
    int          m_acc_t[$];
    int          stall_err;
    int          rdy_busy_err;
    int          busy_cnt;
    int          model_seq = 0;
    bit          timed_out;

    always #5 sys_clk = ~sys_clk;

    sample_packetizer #(.NUM_CHANNELS(NC), .SYNC_BYTE(8'hA5)) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst),
        .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
        .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
        .busy(busy), .seq_num(seq_num)
    );

    sample_packetizer #(.NUM_CHANNELS(1), .SYNC_BYTE(8'hA5)) dut1 (
        .sys_clk(sys_clk), .sys_rst(rst1),
        .s_axis_tdata(s1_tdata), .s_axis_tvalid(s1_tvalid), .s_axis_tready(s1_tready),
        .m_axis_tdata(m1_tdata), .m_axis_tvalid(m1_tvalid), .m_axis_tready(m1_tready),
        .busy(busy1), .seq_num(seq1)
    );

    // Host-side view of one packet built from the framing rules.
    function automatic void model_packet(input logic [31:0] frame, input int seq);
        int          sum;
        logic [15:0] smp;
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'(seq));
        sum = seq;
        for (int ch = 0; ch < NC; ch++) begin
            smp = frame[16*ch +: 16];
            exp_q.push_back(smp[15:8]);
            exp_q.push_back(smp[7:0]);
            sum = sum + int'(smp[15:8]) + int'(smp[7:0]);
        end
        exp_q.push_back(8'(sum % 256));
    endfunction

    // Drives frame_q into the DUT, sinks bytes with the given ready probability
    // and records timing and protocol observations for the calling test.
    task automatic run_stream(input int rdy_pct, input int budget);
        int         cyc = 0;
        int         target;
        bit         prev_stall = 1'b0;
        logic [7:0] prev_data = 8'h00;
        logic       v;
        logic [7:0] d;
        logic       sr;
        got_q.delete(); exp_q.delete(); s_acc_t.delete(); m_acc_t.delete();
        stall_err = 0; rdy_busy_err = 0; busy_cnt = 0;
        target = frame_q.size() * PL;
        while ((frame_q.size() > 0 || got_q.size() < target) && cyc < budget) begin
            @(negedge sys_clk);
            cyc++;
            v  = m_tvalid;
            d  = m_tdata;
            sr = s_tready;
            if (prev_stall && (v !== 1'b1 || d !== prev_data)) stall_err++;
            if (sr && busy) rdy_busy_err++;
            if (busy) busy_cnt++;
            m_tready = ($urandom_range(99) < rdy_pct);
            s_tvalid = (frame_q.size() > 0);
            s_tdata  = (frame_q.size() > 0) ? frame_q[0] : 32'h0;
            if (s_tvalid && sr) begin
                model_packet(frame_q[0], model_seq);
                model_seq = (model_seq + 1) % 256;
                void'(frame_q.pop_front());
                s_acc_t.push_back(cyc);
            end
            if (v && m_tready) begin
                got_q.push_back(d);
                m_acc_t.push_back(cyc);
            end
            prev_stall = v && !m_tready;
            prev_data  = d;
        end
        timed_out = (frame_q.size() > 0 || got_q.size() < target);
        frame_q.delete();
        s_tvalid = 1'b0;
    endtask

    task automatic apply_reset();
        sys_rst  = 1'b1;
        s_tvalid = 1'b0;
        m_tready = 1'b0;
        @(negedge sys_clk);
        @(negedge sys_clk);
        sys_rst   = 1'b0;
        model_seq = 0;
    endtask

    task automatic test_reset();
        @(negedge sys_clk);
        checks += 5;
        if (s_tready !== 1'b0) begin failures++; $display("FAIL reset_s_tready got=%b exp=0", s_tready); end
        if (m_tvalid !== 1'b0) begin failures++; $display("FAIL reset_m_tvalid got=%b exp=0", m_tvalid); end
        if (m_tdata !== 8'h00) begin failures++; $display("FAIL reset_m_tdata got=%h exp=00", m_tdata); end
        if (busy !== 1'b0)     begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        if (seq_num !== 8'h00) begin failures++; $display("FAIL reset_seq got=%h exp=00", seq_num); end
        sys_rst = 1'b0;
        #1;
        checks++;
        if (s_tready !== 1'b0) begin failures++; $display("FAIL release_no_edge got=%b exp=0", s_tready); end
        @(negedge sys_clk);
        checks++;
        if (s_tready !== 1'b1) begin failures++; $display("FAIL ready_after_release got=%b exp=1", s_tready); end
    endtask

    task automatic test_single_frame();
        logic [7:0] tbl [7];
        tbl = '{8'hA5, 8'h00, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'hBE};
        frame_q.push_back({16'hABCD, 16'h1234});
        run_stream(100, 50);
        checks += 2;
        if (timed_out) begin failures++; $display("FAIL single_timeout got=%0d bytes exp=7", got_q.size()); end
        if (got_q.size() !== 7) begin
            failures++; $display("FAIL single_len got=%0d exp=7", got_q.size());
        end else begin
            for (int i = 0; i < 7; i++) begin
                checks++;
                if (got_q[i] !== tbl[i]) begin failures++; $display("FAIL single_byte%0d got=%h exp=%h", i, got_q[i], tbl[i]); end
            end
            checks += 3;
            if (busy_cnt !== 7) begin failures++; $display("FAIL single_busy_cycles got=%0d exp=7", busy_cnt); end
            if (m_acc_t[0] !== s_acc_t[0] + 1) begin failures++; $display("FAIL single_latency got=%0d exp=%0d", m_acc_t[0], s_acc_t[0] + 1); end
            if (m_acc_t[6] !== m_acc_t[0] + 6) begin failures++; $display("FAIL single_consecutive got=%0d exp=%0d", m_acc_t[6], m_acc_t[0] + 6); end
        end
        @(negedge sys_clk);
        checks += 3;
        if (s_tready !== 1'b1) begin failures++; $display("FAIL single_ready_back got=%b exp=1", s_tready); end
        if (m_tvalid !== 1'b0) begin failures++; $display("FAIL single_valid_drop got=%b exp=0", m_tvalid); end
        if (seq_num !== 8'h01) begin failures++; $display("FAIL single_seq_inc got=%h exp=01", seq_num); end
    endtask

    task automatic test_random_backpressure();
        apply_reset();
        for (int i = 0; i < 100; i++) frame_q.push_back($urandom);
        run_stream(50, 5000);
        checks += 4;
        if (timed_out) begin failures++; $display("FAIL rand_timeout got=%0d bytes exp=%0d", got_q.size(), 100 * PL); end
        if (got_q.size() !== exp_q.size()) begin failures++; $display("FAIL rand_len got=%0d exp=%0d", got_q.size(), exp_q.size()); end
        if (stall_err !== 0) begin failures++; $display("FAIL rand_stall_stable got=%0d exp=0", stall_err); end
        if (rdy_busy_err !== 0) begin failures++; $display("FAIL rand_ready_busy got=%0d exp=0", rdy_busy_err); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL rand_byte%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
        end
        for (int p = 0; p < 100 && (p * PL + 1) < got_q.size(); p++) begin
            checks++;
            if (got_q[p*PL+1] !== p[7:0]) begin failures++; $display("FAIL rand_seq%0d got=%h exp=%h", p, got_q[p*PL+1], p[7:0]); end
        end
    endtask

    task automatic test_back_to_back();
        int bad_period = 0;
        apply_reset();
        for (int i = 0; i < 257; i++) frame_q.push_back($urandom);
        run_stream(100, 257 * 8 + 40);
        checks += 5;
        if (timed_out) begin failures++; $display("FAIL b2b_timeout got=%0d bytes exp=%0d", got_q.size(), 257 * PL); end
        if (got_q.size() !== exp_q.size()) begin failures++; $display("FAIL b2b_len got=%0d exp=%0d", got_q.size(), exp_q.size()); end
        if (rdy_busy_err !== 0) begin failures++; $display("FAIL b2b_ready_busy got=%0d exp=0", rdy_busy_err); end
        if (busy_cnt !== 257 * PL) begin failures++; $display("FAIL b2b_busy_cycles got=%0d exp=%0d", busy_cnt, 257 * PL); end
        if (s_acc_t.size() !== 257) begin failures++; $display("FAIL b2b_accepts got=%0d exp=257", s_acc_t.size()); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL b2b_byte%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
        end
        for (int i = 1; i < s_acc_t.size(); i++) begin
            if (s_acc_t[i] - s_acc_t[i-1] !== PL + 1) bad_period++;
        end
        checks++;
        if (bad_period !== 0) begin failures++; $display("FAIL b2b_period got=%0d bad periods exp=0", bad_period); end
        if (got_q.size() >= 257 * PL) begin
            checks += 2;
            if (got_q[255*PL+1] !== 8'hFF) begin failures++; $display("FAIL b2b_seq255 got=%h exp=ff", got_q[255*PL+1]); end
            if (got_q[256*PL+1] !== 8'h00) begin failures++; $display("FAIL b2b_seq_wrap got=%h exp=00", got_q[256*PL+1]); end
        end
    endtask

    task automatic test_reset_mid_packet();
        logic [31:0] frame;
        logic [7:0]  tbl [7];
        int          w = 0;
        tbl = '{8'hA5, 8'h00, 8'h00, 8'h01, 8'h00, 8'h02, 8'h03};
        frame_q.push_back($urandom);
        frame_q.push_back($urandom);
        run_stream(100, 60);
        @(negedge sys_clk);
        checks += 2;
        if (timed_out) begin failures++; $display("FAIL mid_pre_timeout got=%0d bytes exp=%0d", got_q.size(), 2 * PL); end
        if (seq_num !== 8'(model_seq)) begin failures++; $display("FAIL mid_pre_seq got=%h exp=%h", seq_num, 8'(model_seq)); end
        while (s_tready !== 1'b1 && w < 10) begin @(negedge sys_clk); w++; end
        frame    = $urandom;
        s_tdata  = frame;
        s_tvalid = 1'b1;
        m_tready = 1'b1;
        @(negedge sys_clk);
        s_tvalid = 1'b0;
        checks++;
        if (m_tvalid !== 1'b1 || m_tdata !== 8'hA5) begin failures++; $display("FAIL mid_sync got=%b/%h exp=1/a5", m_tvalid, m_tdata); end
        repeat (4) @(negedge sys_clk);
        checks++;
        if (m_tdata !== frame[31:24]) begin failures++; $display("FAIL mid_data_byte3 got=%h exp=%h", m_tdata, frame[31:24]); end
        sys_rst = 1'b1;
        #1;
        checks += 4;
        if (m_tvalid !== 1'b0) begin failures++; $display("FAIL mid_async_valid got=%b exp=0", m_tvalid); end
        if (busy !== 1'b0)     begin failures++; $display("FAIL mid_async_busy got=%b exp=0", busy); end
        if (seq_num !== 8'h00) begin failures++; $display("FAIL mid_async_seq got=%h exp=00", seq_num); end
        if (m_tdata !== 8'h00) begin failures++; $display("FAIL mid_async_data got=%h exp=00", m_tdata); end
        @(negedge sys_clk);
        sys_rst   = 1'b0;
        model_seq = 0;
        frame_q.push_back({16'h0002, 16'h0001});
        run_stream(100, 40);
        checks++;
        if (got_q.size() !== 7) begin
            failures++; $display("FAIL mid_post_len got=%0d exp=7", got_q.size());
        end else begin
            for (int i = 0; i < 7; i++) begin
                checks++;
                if (got_q[i] !== tbl[i]) begin failures++; $display("FAIL mid_post_byte%0d got=%h exp=%h", i, got_q[i], tbl[i]); end
            end
        end
    endtask

    task automatic test_one_channel();
        logic [15:0] f [3];
        logic [7:0]  tbl [5];
        logic [7:0]  q[$];
        int          idx = 0;
        int          cyc = 0;
        int          base;
        f   = '{16'($urandom), 16'($urandom), 16'hFFFF};
        tbl = '{8'hA5, 8'h02, 8'hFF, 8'hFF, 8'h00};
        @(negedge sys_clk);
        rst1      = 1'b0;
        m1_tready = 1'b1;
        while ((idx < 3 || q.size() < 3 * PL1) && cyc < 60) begin
            @(negedge sys_clk);
            cyc++;
            if (m1_tvalid && m1_tready) q.push_back(m1_tdata);
            if (idx < 3) begin
                s1_tvalid = 1'b1;
                s1_tdata  = f[idx];
            end else begin
                s1_tvalid = 1'b0;
                s1_tdata  = 16'h0;
            end
            if (s1_tvalid && s1_tready) idx++;
        end
        s1_tvalid = 1'b0;
        checks++;
        if (q.size() !== 3 * PL1) begin
            failures++; $display("FAIL nc1_len got=%0d exp=%0d", q.size(), 3 * PL1);
        end else begin
            base = q.size() - 5;
            for (int i = 0; i < 5; i++) begin
                checks++;
                if (q[base+i] !== tbl[i]) begin failures++; $display("FAIL nc1_byte%0d got=%h exp=%h", i, q[base+i], tbl[i]); end
            end
        end
        @(negedge sys_clk);
        @(negedge sys_clk);
        checks++;
        if (seq1 !== 8'h03) begin failures++; $display("FAIL nc1_seq got=%h exp=03", seq1); end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_random_backpressure();
        test_back_to_back();
        test_reset_mid_packet();
        test_one_channel();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

endmodule
